// File: rtl/wb16_initiator.sv
// wb16_initiator
// Turns a single-word command handshake into one Wishbone classic read or
// write cycle on the 16-bit channel register bus. A cycle that receives no ack
// within TMO clocks is aborted and reported as an error. A one-clock GAP after
// every cycle absorbs the responders' registered ack, which is still high then.
//
// Ports:
//   wb_clk, wb_rst          clock, synchronous active-high reset
//   cmd_req/we/adr/dat      command in, accepted when cmd_req & cmd_rdy
//   cmd_rdy                 ready for a command (IDLE and not in reset)
//   rsp_valid/dat/err       one-clock response pulse, data, timeout flag
//   wb_cyc/stb/we/adr/dat_o Wishbone initiator outputs
//   wb_dat_i, wb_ack        Wishbone responder inputs
module wb16_initiator #(
  parameter int unsigned ADRBITS = 4,
  parameter int unsigned TMOBITS = 4
) (
  input  logic               wb_clk,
  input  logic               wb_rst,
  input  logic               cmd_req,
  input  logic               cmd_we,
  input  logic [ADRBITS-1:0] cmd_adr,
  input  logic [15:0]        cmd_dat,
  output logic               cmd_rdy,
  output logic               rsp_valid,
  output logic [15:0]        rsp_dat,
  output logic               rsp_err,
  output logic               wb_cyc,
  output logic               wb_stb,
  output logic               wb_we,
  output logic [ADRBITS-1:0] wb_adr,
  output logic [15:0]        wb_dat_o,
  input  logic [15:0]        wb_dat_i,
  input  logic               wb_ack
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [TMOBITS-1:0] TMO = '1;

  logic [1:0]         r_state;
  logic [TMOBITS-1:0] r_tmo;
  logic               w_accept;
  logic               w_timeout;

  assign cmd_rdy   = (r_state == S_IDLE) & ~wb_rst;
  assign w_accept  = cmd_req & cmd_rdy;
  // Ack takes priority over an expiring counter in the same clock.
  assign w_timeout = (r_tmo == TMO) & ~wb_ack;

  assign wb_cyc    = (r_state == S_BUS);
  assign wb_stb    = (r_state == S_BUS);
  assign rsp_valid = (r_state == S_GAP);

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      r_state  <= S_IDLE;
      r_tmo    <= '0;
      rsp_dat  <= '0;
      rsp_err  <= 1'b0;
      wb_we    <= 1'b0;
      wb_adr   <= '0;
      wb_dat_o <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            wb_we    <= cmd_we;
            wb_adr   <= cmd_adr;
            wb_dat_o <= cmd_dat;
            r_tmo    <= '0;
            r_state  <= S_BUS;
          end
        end
        S_BUS: begin
          if (wb_ack) begin
            rsp_dat <= wb_we ? wb_dat_o : wb_dat_i;
            rsp_err <= 1'b0;
            r_state <= S_GAP;
          end else if (w_timeout) begin
            rsp_dat <= '1;
            rsp_err <= 1'b1;
            r_state <= S_GAP;
          end else if (r_tmo != TMO) begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_GAP: begin
          // Any ack seen here is the stale registered ack of the last cycle.
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb16_initiator.sv
module tb_wb16_initiator;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic        cmd_req;
  logic        cmd_we;
  logic [3:0]  cmd_adr;
  logic [15:0] cmd_dat;
  logic        cmd_rdy;
  logic        rsp_valid;
  logic [15:0] rsp_dat;
  logic        rsp_err;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [3:0]  wb_adr;
  logic [15:0] wb_dat_o;
  logic [15:0] wb_dat_i;
  logic        wb_ack;

  int unsigned tests  = 0;
  int unsigned failed = 0;

  always #5 wb_clk = ~wb_clk;

  wb16_initiator #(.ADRBITS(4), .TMOBITS(4)) dut (
    .wb_clk   (wb_clk),
    .wb_rst   (wb_rst),
    .cmd_req  (cmd_req),
    .cmd_we   (cmd_we),
    .cmd_adr  (cmd_adr),
    .cmd_dat  (cmd_dat),
    .cmd_rdy  (cmd_rdy),
    .rsp_valid(rsp_valid),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .wb_cyc   (wb_cyc),
    .wb_stb   (wb_stb),
    .wb_we    (wb_we),
    .wb_adr   (wb_adr),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack   (wb_ack)
  );

  // Responder model: registered ack after slave_dly clocks of cyc&stb
  // (slave_dly = 0 means it never answers); ack stays high while stb does.
  logic [15:0] mem [16];
  int unsigned slave_dly;
  int unsigned scnt;
  logic        slave_ack;
  logic        force_ack;

  assign wb_ack   = slave_ack | force_ack;
  assign wb_dat_i = mem[wb_adr];

  always @(posedge wb_clk) begin
    if (wb_rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 16'(i * 16'h1111);
      mem[3]    <= 16'h1234;
      mem[7]    <= 16'hBEEF;
      mem[14]   <= 16'h0E0E;
      slave_ack <= 1'b0;
      scnt      <= 0;
    end else begin
      if (wb_cyc && wb_stb) scnt <= scnt + 1;
      else                  scnt <= 0;
      slave_ack <= (slave_dly != 0) && wb_cyc && wb_stb && (scnt + 1 >= slave_dly);
      if (wb_cyc && wb_stb && wb_we && wb_ack) mem[wb_adr] <= wb_dat_o;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issues one command at the current negedge (cmd_rdy expected high), follows
  // it to the response and one clock past it.
  task automatic run_cmd(input string nm, input logic we, input logic [3:0] adr,
                         input logic [15:0] dat, input int unsigned dly,
                         input logic [15:0] exp_dat, input logic exp_err,
                         input int unsigned exp_stb);
    int unsigned stb_n;
    int unsigned bad_hold;
    logic        got;
    check({nm, "_rdy_before"}, 32'(cmd_rdy), 32'd1);
    slave_dly = dly;
    cmd_req = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat;
    @(negedge wb_clk);
    cmd_req = 1'b0; cmd_dat = 16'h0000; cmd_adr = 4'h0; cmd_we = ~we;
    stb_n = 0; bad_hold = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (wb_stb) begin
        stb_n++;
        if (wb_adr !== adr || wb_we !== we || (we && wb_dat_o !== dat) || !wb_cyc || cmd_rdy)
          bad_hold++;
      end
      if (rsp_valid) got = 1'b1;
      else @(negedge wb_clk);
    end
    check({nm, "_rsp_seen"}, 32'(got), 32'd1);
    check({nm, "_stb_clocks"}, stb_n, exp_stb);
    check({nm, "_bus_held"}, bad_hold, 32'd0);
    check({nm, "_rsp_dat"}, 32'(rsp_dat), 32'(exp_dat));
    check({nm, "_rsp_err"}, 32'(rsp_err), 32'(exp_err));
    check({nm, "_gap_rdy_cyc"}, {30'd0, cmd_rdy, wb_cyc}, 32'd0);
    @(negedge wb_clk);
    check({nm, "_rdy_after"}, 32'(cmd_rdy), 32'd1);
    check({nm, "_single_rsp"}, 32'(rsp_valid), 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  adr;
    logic [15:0] dat;
    int unsigned dly;
    logic [15:0] exp_dat;
    logic        exp_err;
    int unsigned exp_stb;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int unsigned acc_clk [3];
    logic [15:0] exp_b2b [3];
    int unsigned nacc;
    int unsigned nrsp;
    int unsigned extra;

    //             we    adr    dat       dly exp_dat   err   stb
    vecs[0] = '{1'b0, 4'd3,  16'h0000, 1,  16'h1234, 1'b0, 2};   // basic read
    vecs[1] = '{1'b1, 4'd5,  16'hA5C3, 1,  16'hA5C3, 1'b0, 2};   // write echo
    vecs[2] = '{1'b0, 4'd3,  16'h0000, 0,  16'hFFFF, 1'b1, 16};  // no responder
    vecs[3] = '{1'b0, 4'd3,  16'h0000, 1,  16'h1234, 1'b0, 2};   // recovery
    vecs[4] = '{1'b0, 4'd7,  16'h0000, 15, 16'hBEEF, 1'b0, 16};  // ack at TMO
    vecs[5] = '{1'b1, 4'd0,  16'h5A5A, 3,  16'h5A5A, 1'b0, 4};
    vecs[6] = '{1'b0, 4'd14, 16'h0000, 14, 16'h0E0E, 1'b0, 15};
    vecs[7] = '{1'b0, 4'd0,  16'h0000, 2,  16'h5A5A, 1'b0, 3};   // readback

    wb_rst = 1'b1; cmd_req = 1'b0; cmd_we = 1'b0; cmd_adr = 4'h0; cmd_dat = 16'h0;
    force_ack = 1'b0; slave_dly = 1;

    // Reset state
    repeat (3) @(negedge wb_clk);
    check("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    check("rst_ctl", {26'd0, rsp_valid, rsp_err, wb_cyc, wb_stb, wb_we, 1'b0}, 32'd0);
    check("rst_rsp_dat", 32'(rsp_dat), 32'd0);
    check("rst_wb_adr", 32'(wb_adr), 32'd0);
    check("rst_wb_dat_o", 32'(wb_dat_o), 32'd0);
    wb_rst = 1'b0;
    #1;
    check("rst_release_rdy", 32'(cmd_rdy), 32'd1);

    for (int k = 0; k < 8; k++) begin
      run_cmd($sformatf("v%0d", k), vecs[k].we, vecs[k].adr, vecs[k].dat, vecs[k].dly,
              vecs[k].exp_dat, vecs[k].exp_err, vecs[k].exp_stb);
      if (k == 1) check("slave_mem5", 32'(mem[5]), 32'h0000_A5C3);
    end

    // Ack while idle must be ignored
    force_ack = 1'b1;
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge wb_clk);
      if (rsp_valid || wb_stb || !cmd_rdy || rsp_dat !== 16'h5A5A) extra++;
    end
    force_ack = 1'b0;
    check("idle_ack_ignored", extra, 32'd0);
    @(negedge wb_clk);

    // Back-to-back reads with cmd_req held high
    exp_b2b[0] = 16'h5A5A; exp_b2b[1] = 16'h1111; exp_b2b[2] = 16'h2222;
    slave_dly = 1; cmd_we = 1'b0;
    nacc = 0; nrsp = 0;
    for (int i = 0; i < 24; i++) begin
      if (rsp_valid) begin
        if (nrsp < 3) check($sformatf("b2b_rsp%0d", nrsp), 32'(rsp_dat), 32'(exp_b2b[nrsp]));
        nrsp++;
      end
      if (cmd_rdy) begin
        if (nacc < 3) begin
          cmd_req = 1'b1; cmd_adr = 4'(nacc); acc_clk[nacc] = i; nacc++;
        end else cmd_req = 1'b0;
      end
      @(negedge wb_clk);
    end
    cmd_req = 1'b0;
    check("b2b_accepts", nacc, 32'd3);
    check("b2b_rsp_count", nrsp, 32'd3);
    check("b2b_spacing01", acc_clk[1] - acc_clk[0], 32'd4);
    check("b2b_spacing12", acc_clk[2] - acc_clk[1], 32'd4);

    // Reset during BUS after a timed-out command left rsp_err set
    run_cmd("pre_rst_tmo", 1'b0, 4'd2, 16'h0000, 0, 16'hFFFF, 1'b1, 16);
    slave_dly = 0;
    cmd_req = 1'b1; cmd_we = 1'b1; cmd_adr = 4'd9; cmd_dat = 16'h1357;
    @(negedge wb_clk);
    cmd_req = 1'b0;
    repeat (2) @(negedge wb_clk);
    check("mid_bus_stb", 32'(wb_stb), 32'd1);
    wb_rst = 1'b1;
    @(negedge wb_clk);
    check("mrst_cyc_stb", {30'd0, wb_cyc, wb_stb}, 32'd0);
    check("mrst_rsp", {29'd0, rsp_valid, rsp_err, cmd_rdy}, 32'd0);
    check("mrst_rsp_dat", 32'(rsp_dat), 32'd0);
    check("mrst_wb_regs", {11'd0, wb_we, wb_adr, wb_dat_o}, 32'd0);
    wb_rst = 1'b0;
    #1;
    check("mrst_release_rdy", 32'(cmd_rdy), 32'd1);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge wb_clk);
      if (rsp_valid || wb_stb) extra++;
    end
    check("mrst_no_rsp", extra, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
